// File: rtl/mem_arbiter.sv
// Arbiter sharing a single-port synchronous RAM between the CPU controller and a
// debug/loader port: CPU first, debug on idle CPU or after MAX_WAIT refused cycles.
module mem_arbiter #(
  parameter int AW       = 9,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    cpu_cmd,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_re,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int              WW       = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0]   WAIT_MAX = WW'(MAX_WAIT);

  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  typedef enum logic {
    S_CPU,
    S_DBG_RD
  } state_e;

  state_e          state_q, state_d;
  logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            rd_pend_q, rd_pend_d;
  logic            dbg_rvalid_q, dbg_rvalid_d;
  logic [DW-1:0]   dbg_rdata_q, dbg_rdata_d;

  logic            cpu_act;
  logic            grant;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    cpu_act      = (cpu_cmd == CMD_READ) || (cpu_cmd == CMD_WRITE);
    grant        = dbg_req && !reset && (!cpu_act || (wait_cnt_q == WAIT_MAX));

    ram_addr     = cpu_addr;
    ram_wdata    = cpu_wdata;
    ram_re       = !reset && (cpu_cmd == CMD_READ);
    ram_we       = !reset && (cpu_cmd == CMD_WRITE);
    dbg_gnt      = 1'b0;
    cpu_stall    = 1'b0;

    state_d      = S_CPU;
    rd_pend_d    = 1'b0;
    wait_cnt_d   = '0;
    dbg_rvalid_d = 1'b0;
    dbg_rdata_d  = dbg_rdata_q;

    // A forced grant over a CPU write simply drops that write; the stalled CPU
    // holds its command and replays it next cycle.
    if (grant) begin
      ram_addr  = dbg_addr;
      ram_wdata = dbg_wdata;
      ram_re    = !dbg_we;
      ram_we    = dbg_we;
      dbg_gnt   = 1'b1;
      cpu_stall = cpu_act;
      if (!dbg_we) begin
        state_d   = S_DBG_RD;
        rd_pend_d = 1'b1;
      end
    end else if (dbg_req && (wait_cnt_q != WAIT_MAX)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end else if (dbg_req) begin
      wait_cnt_d = wait_cnt_q;
    end

    // ram_rdata this cycle answers the debug read granted last cycle.
    if ((state_q == S_DBG_RD) && rd_pend_q) begin
      dbg_rvalid_d = 1'b1;
      dbg_rdata_d  = ram_rdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_CPU;
      wait_cnt_q   <= '0;
      rd_pend_q    <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      rd_pend_q    <= rd_pend_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign cpu_rdata  = ram_rdata;
  assign dbg_rvalid = dbg_rvalid_q;
  assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM, a cycle-level reference model checked every
// cycle, and directed scenarios with hand-computed literal expectations.
module tb_mem_arbiter;

  localparam int AW       = 9;
  localparam int DW       = 16;
  localparam int MAX_WAIT = 4;
  localparam int DEPTH    = 1 << AW;

  logic          clk;
  logic          reset;
  logic [1:0]    cpu_cmd;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_re;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_cmd    (cpu_cmd),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .ram_addr   (ram_addr),
    .ram_re     (ram_re),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] init_word(input int i);
    return DW'(i * 37 + 11);
  endfunction

  // Single-port RAM, one-cycle synchronous read.
  logic [DW-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
    mem[5]    = 16'hABCD;
    mem[32]   = 16'h5A5A;
    ram_rdata = '0;
    forever begin
      @(posedge clk);
      if (ram_we) mem[ram_addr] <= ram_wdata;
      if (ram_re) ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: evaluated on every falling edge with the inputs that will be
  // sampled at the next rising edge.
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] rv_due    [int];
  logic [DW-1:0] cpu_due   [int];

  initial begin
    int            c;
    int            refused;
    bit            regs_ok;
    logic [DW-1:0] exp_rdata;
    bit            act, g, e_re, e_we, e_stall, e_rvalid;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    int            drop [$];

    for (int i = 0; i < DEPTH; i++) model_mem[i] = init_word(i);
    model_mem[5]  = 16'hABCD;
    model_mem[32] = 16'h5A5A;
    c = 0; refused = 0; regs_ok = 0; exp_rdata = '0;

    forever begin
      @(negedge clk);
      act = (cpu_cmd == 2'd1) || (cpu_cmd == 2'd2);
      g   = dbg_req && !reset && (!act || refused == MAX_WAIT);
      if (g) begin
        e_re = !dbg_we; e_we = dbg_we; e_addr = dbg_addr; e_wd = dbg_wdata; e_stall = act;
      end else begin
        e_re = !reset && cpu_cmd == 2'd1; e_we = !reset && cpu_cmd == 2'd2;
        e_addr = cpu_addr; e_wd = cpu_wdata; e_stall = 1'b0;
      end
      e_rvalid = rv_due.exists(c);
      if (e_rvalid) begin
        exp_rdata = rv_due[c];
        rv_due.delete(c);
      end

      check("m_dbg_gnt", 32'(dbg_gnt), 32'(g));
      check("m_cpu_stall", 32'(cpu_stall), 32'(e_stall));
      check("m_ram_re", 32'(ram_re), 32'(e_re));
      check("m_ram_we", 32'(ram_we), 32'(e_we));
      if (e_re || e_we) check("m_ram_addr", 32'(ram_addr), 32'(e_addr));
      if (e_we) check("m_ram_wdata", 32'(ram_wdata), 32'(e_wd));
      if (regs_ok) begin
        check("m_dbg_rvalid", 32'(dbg_rvalid), 32'(e_rvalid));
        check("m_dbg_rdata", 32'(dbg_rdata), 32'(exp_rdata));
      end
      if (cpu_due.exists(c)) begin
        check("m_cpu_rdata", 32'(cpu_rdata), 32'(cpu_due[c]));
        cpu_due.delete(c);
      end

      if (e_re && g)  rv_due[c + 2]  = model_mem[e_addr];
      if (e_re && !g) cpu_due[c + 1] = model_mem[e_addr];
      if (e_we) model_mem[e_addr] = e_wd;
      if (reset || !dbg_req || g) refused = 0;
      else if (refused < MAX_WAIT) refused++;
      if (reset) begin
        drop.delete();
        foreach (rv_due[k]) if (k > c) drop.push_back(k);
        foreach (drop[i]) rv_due.delete(drop[i]);
        exp_rdata = '0;
        regs_ok   = 1'b1;
      end
      c++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cpu(input logic [1:0] cmd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_cmd = cmd; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic drive_dbg(input logic req, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
  endtask

  initial begin
    reset = 1'b1;
    drive_cpu(2'b10, 9'h001, 16'hDEAD);
    drive_dbg(1'b1, 1'b1, 9'h002, 16'hBEEF);

    // Reset with both requesters active.
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      check("rst_ram_we", 32'(ram_we), 32'd0);
      check("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
      check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
      if (i == 2) begin
        check("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        check("rst_dbg_rdata", 32'(dbg_rdata), 32'd0);
      end
      tick();
    end
    reset = 1'b0;
    drive_cpu(2'b00, '0, '0);
    drive_dbg(1'b0, 1'b0, '0, '0);
    tick();

    // CPU-only read.
    drive_cpu(2'b01, 9'h005, '0);
    @(negedge clk);
    check("cpu_rd_re", 32'(ram_re), 32'd1);
    check("cpu_rd_addr", 32'(ram_addr), 32'h005);
    tick();
    drive_cpu(2'b00, '0, '0);
    @(negedge clk);
    check("cpu_rd_data", 32'(cpu_rdata), 32'hABCD);
    check("cpu_rd_stall", 32'(cpu_stall), 32'd0);
    tick();

    // Idle CPU: debug write granted immediately.
    drive_dbg(1'b1, 1'b1, 9'h010, 16'h1234);
    @(negedge clk);
    check("idle_gnt", 32'(dbg_gnt), 32'd1);
    check("idle_we", 32'(ram_we), 32'd1);
    tick();
    drive_dbg(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("idle_ram16", 32'(mem[16]), 32'h1234);
    tick();

    // Reserved command 11 behaves as NONE.
    drive_cpu(2'b11, 9'h044, 16'h7777);
    @(negedge clk);
    check("cmd11_re", 32'(ram_re), 32'd0);
    check("cmd11_we", 32'(ram_we), 32'd0);
    tick();
    drive_dbg(1'b1, 1'b1, 9'h045, 16'h4545);
    @(negedge clk);
    check("cmd11_gnt", 32'(dbg_gnt), 32'd1);
    check("cmd11_stall", 32'(cpu_stall), 32'd0);
    tick();
    drive_dbg(1'b0, 1'b0, '0, '0);
    drive_cpu(2'b00, '0, '0);
    tick();

    // Starvation: CPU reads continuously, debug read forced in on cycle 5.
    drive_cpu(2'b01, 9'h007, '0);
    drive_dbg(1'b1, 1'b0, 9'h020, '0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check($sformatf("starve_gnt_%0d", i), 32'(dbg_gnt), 32'(i == 5));
      check($sformatf("starve_stall_%0d", i), 32'(cpu_stall), 32'(i == 5));
      check($sformatf("starve_rvalid_%0d", i), 32'(dbg_rvalid), 32'(i == 7));
      if (i == 5) check("starve_cpu_rdata", 32'(cpu_rdata), 32'(init_word(7)));
      if (i == 7) check("starve_rdata", 32'(dbg_rdata), 32'h5A5A);
      tick();
      if (i == 5) dbg_req = 1'b0;
    end

    // Write collision: forced debug write suppresses the CPU write, CPU replays.
    drive_cpu(2'b01, 9'h031, '0);
    drive_dbg(1'b1, 1'b1, 9'h030, 16'h2222);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("coll_refuse_%0d", i), 32'(dbg_gnt), 32'd0);
      tick();
    end
    drive_cpu(2'b10, 9'h030, 16'h1111);
    @(negedge clk);
    check("coll_gnt", 32'(dbg_gnt), 32'd1);
    check("coll_stall", 32'(cpu_stall), 32'd1);
    check("coll_wdata1", 32'(ram_wdata), 32'h2222);
    tick();
    dbg_req = 1'b0;
    @(negedge clk);
    check("coll_cpu_we", 32'(ram_we), 32'd1);
    check("coll_wdata2", 32'(ram_wdata), 32'h1111);
    tick();
    drive_cpu(2'b00, '0, '0);
    @(negedge clk);
    check("coll_ram48", 32'(mem[48]), 32'h1111);
    tick();

    // Back-to-back debug reads with idle CPU.
    drive_dbg(1'b1, 1'b0, 9'h005, '0);
    tick();
    dbg_addr = 9'h020;
    tick();
    dbg_req = 1'b0;
    @(negedge clk);
    check("b2b_rvalid1", 32'(dbg_rvalid), 32'd1);
    check("b2b_rdata1", 32'(dbg_rdata), 32'hABCD);
    tick();
    @(negedge clk);
    check("b2b_rvalid2", 32'(dbg_rvalid), 32'd1);
    check("b2b_rdata2", 32'(dbg_rdata), 32'h5A5A);
    tick();
    @(negedge clk);
    check("b2b_rvalid3", 32'(dbg_rvalid), 32'd0);
    check("b2b_hold", 32'(dbg_rdata), 32'h5A5A);
    tick();

    // Reset while a debug read is in flight.
    drive_dbg(1'b1, 1'b0, 9'h005, '0);
    @(negedge clk);
    check("rstrd_gnt", 32'(dbg_gnt), 32'd1);
    tick();
    reset = 1'b1;
    dbg_req = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rstrd_rvalid", 32'(dbg_rvalid), 32'd0);
    check("rstrd_rdata", 32'(dbg_rdata), 32'd0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
